// File: rtl/dram_bist_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dram_bist_ctrl_if
// Bundles the request/status handshake and the distributed-RAM port of the
// DRAM BIST controller.
//   start          controller <- requester : one-cycle test request
//   busy/done/pass controller -> requester : run status, completion pulse, result
//   err_cnt        controller -> requester : mismatch count (ADDR_W+2 bits)
//   ram_addr/di/we controller -> RAM       : shared address, write data, write enable
//   ram_do         RAM -> controller       : asynchronous read data of ram_addr
// Optional (DRAM_BIST_ERR_ADDR_EN): first_err_vld/addr/data, capture of the
// first mismatching read of a test.
// Modports: master = controller side, slave = requester/RAM side.
// ---------------------------------------------------------------------------
interface dram_bist_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W+1:0] err_cnt;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_di;
  logic              ram_we;
  logic [DATA_W-1:0] ram_do;
`ifdef DRAM_BIST_ERR_ADDR_EN
  logic              first_err_vld;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;

  modport master (
    input  start, ram_do,
    output busy, done, pass, err_cnt, ram_addr, ram_di, ram_we,
    output first_err_vld, first_err_addr, first_err_data
  );

  modport slave (
    output start, ram_do,
    input  busy, done, pass, err_cnt, ram_addr, ram_di, ram_we,
    input  first_err_vld, first_err_addr, first_err_data
  );
`else
  modport master (
    input  start, ram_do,
    output busy, done, pass, err_cnt, ram_addr, ram_di, ram_we
  );

  modport slave (
    output start, ram_do,
    input  busy, done, pass, err_cnt, ram_addr, ram_di, ram_we
  );
`endif
endinterface

// File: rtl/dram_bist_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dram_bist_ctrl
// Built-in self-test sequencer for a 2**ADDR_W x DATA_W distributed RAM
// (synchronous write on clk, asynchronous read). Runs a four-pass march:
// write P, read/check P, write ~P, read/check ~P, with
// P(a) = zero_ext(a) ^ SEED, ascending addresses in every pass.
//
// Ports
//   clk    : single clock, also the RAM write clock
//   rst_n  : synchronous, active-low reset
//   bus    : dram_bist_ctrl_if.master
//            start (in), busy/done/pass/err_cnt (out),
//            ram_addr/ram_di/ram_we (out, registered), ram_do (in)
//
// Optional feature macro: DRAM_BIST_ERR_ADDR_EN
//   Adds first_err_vld/first_err_addr/first_err_data, capturing the address
//   and read data of the first mismatch of a test.
//
// Timing: busy is high for 4*2**ADDR_W + 1 cycles; the extra cycle (FLUSH)
// finishes the compare of the last RD1 address. done pulses in the first
// cycle with busy low. No combinational path exists from ram_do to outputs.
// ---------------------------------------------------------------------------
module dram_bist_ctrl #(
  parameter int                ADDR_W = 6,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  dram_bist_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR0   = 3'd1,
    RD0   = 3'd2,
    WR1   = 3'd3,
    RD1   = 3'd4,
    FLUSH = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W+1:0] ERR_ONE   = (ADDR_W+2)'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr_nxt;
  logic              last_addr;

  logic              vld_p1;
  logic [DATA_W-1:0] rd_p1;
  logic [DATA_W-1:0] exp_p1;
  logic              err_hit;
`ifdef DRAM_BIST_ERR_ADDR_EN
  logic [ADDR_W-1:0] addr_p1;
`endif

  // March data pattern; inv selects the complemented passes.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic              inv);
    logic [DATA_W-1:0] p;
    p = DATA_W'(a) ^ SEED;
    return inv ? ~p : p;
  endfunction

  // The address counter is exactly ADDR_W bits wide, so the increment past
  // the last address wraps to 0, which is also the first address of the
  // following pass.
  always_comb begin
    addr_nxt  = bus.ram_addr + ADDR_ONE;
    last_addr = (bus.ram_addr == ADDR_LAST);
  end

  // ---- stage p1: capture read data and its expected value at the edge
  // ending each read address cycle (data path, no reset) ----
  always_ff @(posedge clk) begin
    rd_p1  <= bus.ram_do;
    exp_p1 <= pattern(bus.ram_addr, state == RD1);
`ifdef DRAM_BIST_ERR_ADDR_EN
    addr_p1 <= bus.ram_addr;
`endif
  end

  // ---- stage p2: whole-word compare, one cycle after capture ----
  always_comb begin
    err_hit = vld_p1 && (rd_p1 != exp_p1);
  end

  // Sequencer, result tracking and registered RAM/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      vld_p1       <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass     <= 1'b0;
      bus.err_cnt  <= '0;
      bus.ram_addr <= '0;
      bus.ram_di   <= '0;
      bus.ram_we   <= 1'b0;
`ifdef DRAM_BIST_ERR_ADDR_EN
      bus.first_err_vld  <= 1'b0;
      bus.first_err_addr <= '0;
      bus.first_err_data <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      vld_p1   <= (state == RD0) || (state == RD1);

      if (err_hit) begin
        bus.err_cnt <= bus.err_cnt + ERR_ONE;
`ifdef DRAM_BIST_ERR_ADDR_EN
        if (!bus.first_err_vld) begin
          bus.first_err_vld  <= 1'b1;
          bus.first_err_addr <= addr_p1;
          bus.first_err_data <= rd_p1;
        end
`endif
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= WR0;
            bus.busy     <= 1'b1;
            bus.pass     <= 1'b0;
            bus.err_cnt  <= '0;
            bus.ram_addr <= '0;
            bus.ram_we   <= 1'b1;
            bus.ram_di   <= pattern('0, 1'b0);
`ifdef DRAM_BIST_ERR_ADDR_EN
            bus.first_err_vld  <= 1'b0;
            bus.first_err_addr <= '0;
            bus.first_err_data <= '0;
`endif
          end
        end

        WR0: begin
          bus.ram_addr <= addr_nxt;
          if (last_addr) begin
            state      <= RD0;
            bus.ram_we <= 1'b0;
          end else begin
            bus.ram_di <= pattern(addr_nxt, 1'b0);
          end
        end

        RD0: begin
          bus.ram_addr <= addr_nxt;
          if (last_addr) begin
            state      <= WR1;
            bus.ram_we <= 1'b1;
            bus.ram_di <= pattern('0, 1'b1);
          end
        end

        WR1: begin
          bus.ram_addr <= addr_nxt;
          if (last_addr) begin
            state      <= RD1;
            bus.ram_we <= 1'b0;
          end else begin
            bus.ram_di <= pattern(addr_nxt, 1'b1);
          end
        end

        RD1: begin
          bus.ram_addr <= addr_nxt;
          if (last_addr) begin
            state <= FLUSH;
          end
        end

        FLUSH: begin
          // The last compare lands on this same edge, so the verdict folds
          // it in rather than looking at the not-yet-updated counter.
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.pass <= (bus.err_cnt == '0) && !err_hit;
        end

        default: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_bist_ctrl.sv
`timescale 1ns/1ps
module tb_dram_bist_ctrl;

  localparam int         ADDR_W = 6;
  localparam int         DATA_W = 8;
  localparam int         DEPTH  = 64;
  localparam int         RUN_LEN = 4 * DEPTH + 1;
  localparam logic [7:0] SEED   = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Distributed RAM model with a stuck-at fault on its read port:
  // read = (stored & and_mask) | or_mask.
  logic [7:0] mem [DEPTH];
  logic [7:0] and_mask = 8'hFF;
  logic [7:0] or_mask  = 8'h00;

  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_di;
  end

  assign bus.ram_do = (mem[bus.ram_addr] & and_mask) | or_mask;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, straight from the march definition.
  function automatic logic [7:0] pat(input int a, input bit inv);
    logic [7:0] p;
    p = 8'(a) ^ SEED;
    return inv ? ~p : p;
  endfunction

  function automatic logic [7:0] faulty(input logic [7:0] v);
    return (v & and_mask) | or_mask;
  endfunction

  // Cycle k of a run (k=0 is the first WR0 cycle): pass k/DEPTH, address k%DEPTH.
  function automatic logic exp_we(input int k);
    return (k < 4 * DEPTH) && (((k / DEPTH) % 2) == 0);
  endfunction

  function automatic logic [7:0] exp_di(input int k);
    return pat(k % DEPTH, k >= 2 * DEPTH);
  endfunction

  // Errors = reads in RD0 (data P) and RD1 (data ~P) whose faulty value differs.
  function automatic int model_errs(input int n_rd0, input int n_rd1);
    int e;
    e = 0;
    for (int a = 0; a < n_rd0; a++) if (faulty(pat(a, 1'b0)) != pat(a, 1'b0)) e++;
    for (int a = 0; a < n_rd1; a++) if (faulty(pat(a, 1'b1)) != pat(a, 1'b1)) e++;
    return e;
  endfunction

  task automatic run_bist(input logic [7:0] am, input logic [7:0] om,
                          input bit repulse, input string tag);
    int         exp_err;
    int         k;
    int         bad;
    int         bad_k;
    int         done_early;
    logic [5:0] cap0_addr, cap63_addr;
    logic [7:0] cap0_di, cap63_di, cap128_di;
    logic       cap0_we;
`ifdef DRAM_BIST_ERR_ADDR_EN
    bit         f_found;
    int         f_addr;
    logic [7:0] f_data;
`endif
    and_mask = am;
    or_mask  = om;
    exp_err  = model_errs(DEPTH, DEPTH);
    cap0_addr = 'x; cap63_addr = 'x; cap0_di = 'x; cap63_di = 'x; cap128_di = 'x; cap0_we = 1'bx;

    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    k = 0; bad = 0; bad_k = -1; done_early = 0;
    while (bus.busy === 1'b1 && k < 400) begin
      if (k == 0)   begin cap0_addr = bus.ram_addr; cap0_di = bus.ram_di; cap0_we = bus.ram_we; end
      if (k == 63)  begin cap63_addr = bus.ram_addr; cap63_di = bus.ram_di; end
      if (k == 128) cap128_di = bus.ram_di;
      if (k < RUN_LEN) begin
        if (bus.ram_addr !== 6'(k % DEPTH) || bus.ram_we !== exp_we(k) ||
            (exp_we(k) && bus.ram_di !== exp_di(k))) begin
          if (bad == 0) bad_k = k;
          bad++;
        end
      end
      if (bus.done !== 1'b0) done_early++;
      bus.start = repulse && (k == 10 || k == 200);
      k++;
      @(negedge clk);
    end
    bus.start = 1'b0;

    n_checks++;
    if (cap0_addr !== 6'd0 || cap0_di !== 8'hA5 || cap0_we !== 1'b1)
      $display("FAIL %s first_wr0: got addr=%0d di=%h we=%b want addr=0 di=a5 we=1", tag, cap0_addr, cap0_di, cap0_we);
    else n_pass++;
    n_checks++;
    if (cap63_addr !== 6'd63 || cap63_di !== 8'h9A)
      $display("FAIL %s last_wr0: got addr=%0d di=%h want addr=63 di=9a", tag, cap63_addr, cap63_di);
    else n_pass++;
    n_checks++;
    if (cap128_di !== 8'h5A) $display("FAIL %s first_wr1: got di=%h want 5a", tag, cap128_di);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL %s ram_seq: got %0d bad cycles (first k=%0d) want 0", tag, bad, bad_k);
    else n_pass++;
    n_checks++;
    if (done_early !== 0) $display("FAIL %s done_while_busy: got %0d want 0", tag, done_early);
    else n_pass++;
    n_checks++;
    if (k !== RUN_LEN) $display("FAIL %s busy_len: got %0d want %0d", tag, k, RUN_LEN);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b1) $display("FAIL %s done_pulse: got %b want 1", tag, bus.done);
    else n_pass++;
    n_checks++;
    if (bus.err_cnt !== 8'(exp_err)) $display("FAIL %s err_cnt: got %0d want %0d", tag, bus.err_cnt, exp_err);
    else n_pass++;
    n_checks++;
    if (bus.pass !== (exp_err == 0)) $display("FAIL %s pass: got %b want %b", tag, bus.pass, exp_err == 0);
    else n_pass++;
`ifdef DRAM_BIST_ERR_ADDR_EN
    f_found = 1'b0; f_addr = 0; f_data = 8'h00;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < DEPTH; a++)
        if (!f_found && faulty(pat(a, ph != 0)) != pat(a, ph != 0)) begin
          f_found = 1'b1; f_addr = a; f_data = faulty(pat(a, ph != 0));
        end
    n_checks++;
    if (bus.first_err_vld !== f_found ||
        (f_found && (bus.first_err_addr !== 6'(f_addr) || bus.first_err_data !== f_data)))
      $display("FAIL %s first_err: got vld=%b addr=%0d data=%h want vld=%b addr=%0d data=%h", tag,
               bus.first_err_vld, bus.first_err_addr, bus.first_err_data, f_found, f_addr, f_data);
    else n_pass++;
`endif
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pass !== (exp_err == 0))
      $display("FAIL %s after_done: got done=%b busy=%b pass=%b want done=0 busy=0 pass=%b", tag,
               bus.done, bus.busy, bus.pass, exp_err == 0);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0)
      $display("FAIL reset_status: got busy=%b done=%b pass=%b want 0 0 0", bus.busy, bus.done, bus.pass);
    else n_pass++;
    n_checks++;
    if (bus.ram_we !== 1'b0 || bus.ram_addr !== 6'd0 || bus.err_cnt !== 8'd0)
      $display("FAIL reset_ram: got we=%b addr=%0d err=%0d want 0 0 0", bus.ram_we, bus.ram_addr, bus.err_cnt);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_run();
    run_bist(8'hFF, 8'h00, 1'b0, "good");
  endtask

  task automatic test_stuck_bit0();
    run_bist(8'hFE, 8'h00, 1'b0, "bit0_sa0");
    n_checks++;
    if (bus.err_cnt !== 8'd64 || bus.pass !== 1'b0)
      $display("FAIL bit0_sa0 totals: got err=%0d pass=%b want err=64 pass=0", bus.err_cnt, bus.pass);
    else n_pass++;
`ifdef DRAM_BIST_ERR_ADDR_EN
    n_checks++;
    if (bus.first_err_vld !== 1'b1 || bus.first_err_addr !== 6'd0 || bus.first_err_data !== 8'hA4)
      $display("FAIL bit0_sa0 first_err: got vld=%b addr=%0d data=%h want 1 0 a4",
               bus.first_err_vld, bus.first_err_addr, bus.first_err_data);
    else n_pass++;
`endif
  endtask

  task automatic test_stuck_zero();
    run_bist(8'h00, 8'h00, 1'b0, "do_zero");
    n_checks++;
    if (bus.err_cnt !== 8'd128 || bus.pass !== 1'b0)
      $display("FAIL do_zero totals: got err=%0d pass=%b want err=128 pass=0", bus.err_cnt, bus.pass);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    run_bist(8'hFF, 8'h00, 1'b1, "repulse");
  endtask

  task automatic test_reset_mid();
    int exp_err;
    and_mask = 8'hFE;
    or_mask  = 8'h00;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    // Now at k=0; move to RD0 address 20. Compares for addresses 0..18 have landed.
    repeat (DEPTH + 20) @(negedge clk);
    exp_err = model_errs(19, 0);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.err_cnt !== 8'(exp_err))
      $display("FAIL mid_rd0_state: got busy=%b err=%0d want busy=1 err=%0d", bus.busy, bus.err_cnt, exp_err);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0 || bus.err_cnt !== 8'd0 || bus.done !== 1'b0)
      $display("FAIL mid_reset: got busy=%b we=%b err=%0d done=%b want 0 0 0 0",
               bus.busy, bus.ram_we, bus.err_cnt, bus.done);
    else n_pass++;
    @(negedge clk);
    run_bist(8'hFF, 8'h00, 1'b0, "after_reset");
  endtask

  task automatic test_random_faults();
    logic [7:0] am, om;
    for (int i = 0; i < 4; i++) begin
      am = 8'($urandom);
      om = 8'($urandom) & 8'($urandom) & ~am;
      run_bist(am, om, 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_run();
    test_stuck_bit0();
    test_stuck_zero();
    test_start_ignored();
    test_reset_mid();
    test_random_faults();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
